// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//   Memory-side responder for the CPU data-memory port. It accepts one
//   load/store at a time over a req/ack handshake and inserts WAIT_CYCLES wait
//   states before completing. Storage is word-addressed, and stores use byte
//   enables. This block stands in for the zero-latency data memory so the
//   datapath can run against slow memory.
//
//   Optional feature macro: DM_RESP_ERR_EN
//     defined   : err pulses with ack for any out-of-range access
//     undefined : err is tied to 0
//
//   Ports
//     clk    in   1       clock, rising edge
//     rst    in   1       asynchronous active-low reset
//     req    in   1       request, sampled only while idle
//     we     in   1       1 = store, 0 = load
//     addr   in   ADDR_W  word address
//     wdata  in   32      store data
//     be     in   4       byte enables, be[i] -> wdata[8i+7:8i]
//     rdata  out  32      load data, valid with ack, held until next load ack
//     ack    out  1       one-cycle completion pulse
//     busy   out  1       high whenever the responder is not idle
//     err    out  1       out-of-range flag, coincident with ack
// -----------------------------------------------------------------------------
module dm_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // FSM state and wait counter
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    // Latched request
    logic               we_q,    we_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [BE_W-1:0]    be_q,    be_d;

    // Registered outputs
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               ack_q,   ack_d;
    logic               busy_q,  busy_d;

    // Storage (not reset: contents survive rst)
    logic [DATA_W-1:0]  mem_q [DEPTH];

    // Access currently being completed
    logic               acc_we_c;
    logic [ADDR_W-1:0]  acc_addr_c;
    logic [DATA_W-1:0]  acc_wdata_c;
    logic [BE_W-1:0]    acc_be_c;
    logic               in_range_c;
    logic [IDX_W-1:0]   idx_c;
    logic               enter_done_c;
    logic               commit_c;

    // With no wait states the access completes on the accepting edge, before
    // the latched copy exists, so idle uses the live inputs.
    always_comb begin
        acc_we_c    = we_q;
        acc_addr_c  = addr_q;
        acc_wdata_c = wdata_q;
        acc_be_c    = be_q;
        if (state_q == S_IDLE) begin
            acc_we_c    = we;
            acc_addr_c  = addr;
            acc_wdata_c = wdata;
            acc_be_c    = be;
        end
    end

    // Range check and array index
    always_comb begin
        in_range_c = (32'(acc_addr_c) < DEPTH);
        idx_c      = IDX_W'(acc_addr_c);
    end

    // Next-state, counter and request latch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = be;
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                // Counter is only reloaded from idle, so it never wraps.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                if (cnt_q <= CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Completion: store commit, load data, ack/busy
    always_comb begin
        enter_done_c = (state_d == S_DONE) && (state_q != S_DONE);
        commit_c     = enter_done_c && acc_we_c && in_range_c;

        rdata_d = rdata_q;
        if (enter_done_c && !acc_we_c) begin
            rdata_d = in_range_c ? mem_q[idx_c] : '0;
        end

        ack_d  = enter_done_c;
        busy_d = (state_d != S_IDLE);
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Byte-enabled store into the array
    always_ff @(posedge clk) begin
        if (commit_c) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (acc_be_c[i]) begin
                    mem_q[idx_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
                end
            end
        end
    end

`ifdef DM_RESP_ERR_EN
    // Out-of-range flag, pulses with ack
    logic err_q, err_d;

    always_comb begin
        err_d = enter_done_c && !in_range_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
//   Randomised self-checking bench for dm_responder. The main instance uses
//   two wait states and a 512-word array inside a 10-bit address space. A
//   second instance uses zero wait states and exercises back-to-back requests.
//   Expected values come from a plain word-array model of the memory.
// -----------------------------------------------------------------------------
module tb_dm_responder;

    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned DEPTH       = 512;
    localparam int unsigned WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;

    logic        req, we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack, busy, err;

    logic        req0, we0;
    logic [9:0]  addr0;
    logic [31:0] wdata0;
    logic [3:0]  be0;
    logic [31:0] rdata0;
    logic        ack0, busy0, err0;

    always #5 clk = ~clk;

    dm_responder #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .be    (be),
        .rdata (rdata),
        .ack   (ack),
        .busy  (busy),
        .err   (err)
    );

    dm_responder #(
        .ADDR_W      (10),
        .DEPTH       (1024),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk   (clk),
        .rst   (rst),
        .req   (req0),
        .we    (we0),
        .addr  (addr0),
        .wdata (wdata0),
        .be    (be0),
        .rdata (rdata0),
        .ack   (ack0),
        .busy  (busy0),
        .err   (err0)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [1024];
    logic [31:0] exp_rdata;
    int unsigned pool [21] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                               88, 511, 512, 600, 1023};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  b);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // One complete access on the main instance, checked against the model.
    task automatic access(input logic w, input logic [9:0] a,
                          input logic [31:0] wd, input logic [3:0] b);
        bit oob;
        bit seen;
        int cyc;
        logic exp_err;
        oob = (32'(a) >= DEPTH);
`ifdef DM_RESP_ERR_EN
        exp_err = oob;
`else
        exp_err = 1'b0;
`endif
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = wd; be = b;
        @(posedge clk);
        #1;
        // Scramble the inputs after acceptance; only the latched copy may matter.
        req = 1'b0; we = 1'($urandom); addr = 10'($urandom);
        wdata = $urandom; be = 4'($urandom);

        if (w) begin
            if (!oob) model[a] = merge_bytes(model[a], wd, b);
        end else begin
            exp_rdata = oob ? 32'h0 : model[a];
        end

        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 16) begin
            @(negedge clk);
            cyc++;
            if (ack === 1'b1) seen = 1'b1;
            else check_eq("busy_wait", 32'(busy), 32'd1);
        end
        check_eq("ack_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(cyc), 32'(WAIT_CYCLES + 1));
        check_eq("rdata_ack", rdata, exp_rdata);
        check_eq("err_ack", 32'(err), 32'(exp_err));
        check_eq("busy_ack", 32'(busy), 32'd1);

        @(negedge clk);
        check_eq("ack_drop", 32'(ack), 32'd0);
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("rdata_hold", rdata, exp_rdata);
        check_eq("err_drop", 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
        exp_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;

        // Reset state
        #1;
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_busy0", 32'(busy0), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Give every in-range pool address a known value
        for (int i = 0; i < 21; i++) begin
            if (pool[i] < DEPTH) access(1'b1, 10'(pool[i]), $urandom, 4'hF);
        end

        // Full-word store then load
        access(1'b1, 10'd3, 32'hDEADBEEF, 4'hF);
        access(1'b0, 10'd3, 32'h0, 4'h0);
        check_eq("t2_load", rdata, 32'hDEADBEEF);

        // Partial byte store and no-op store
        access(1'b1, 10'd7, 32'h11223344, 4'hF);
        access(1'b1, 10'd7, 32'h0000AB00, 4'b0010);
        access(1'b0, 10'd7, 32'h0, 4'hF);
        check_eq("t3_merge", rdata, 32'h1122AB44);
        access(1'b1, 10'd7, 32'hFFFFFFFF, 4'b0000);
        access(1'b0, 10'd7, 32'h0, 4'h0);
        check_eq("t3_be0", rdata, 32'h1122AB44);

        // Reset in the middle of a store's wait states
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 10'd5; wdata = 32'h12345678; be = 4'hF;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_rdata = 32'h0;
        check_eq("t1_busy", 32'(busy), 32'd0);
        check_eq("t1_ack", 32'(ack), 32'd0);
        check_eq("t1_rdata", rdata, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t1_no_ack", 32'(ack), 32'd0);
        end
        rst = 1'b1;
        access(1'b0, 10'd5, 32'h0, 4'h0);

        // Out-of-range load and store, with no aliasing onto addr 88
        access(1'b0, 10'd7, 32'h0, 4'h0);
        access(1'b0, 10'd600, 32'h0, 4'h0);
        check_eq("t5_oob_rdata", rdata, 32'h0);
        access(1'b1, 10'd600, 32'hBAD0BAD0, 4'hF);
        access(1'b0, 10'd88, 32'h0, 4'h0);

        // Zero wait states with req held high: ack and busy alternate
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd0; be0 = 4'h0; wdata0 = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("t4_ack", 32'(ack0), (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("t4_busy", 32'(busy0), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t4_idle", 32'(busy0), 32'd0);
        check_eq("t4_err0", 32'(err0), 32'd0);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            access(1'($urandom), 10'(pool[$urandom_range(0, 20)]), $urandom, 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
